// File: rtl/btb_gshare_predictor_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
//   ctr_t      : 2-bit saturating direction counter encoding
//   CTR_INIT   : value every PHT entry takes during the init sweep
//   ctr_next   : saturating counter update
//   bp_state_t : init-sweep / run state of the predictor
// The BTB entry struct depends on module parameters (tag/target widths),
// so it is declared inside the top module instead of here.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT = CTR_WNT;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_t;

    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        if (taken) return (c == CTR_ST)  ? CTR_ST  : ctr_t'(c + 2'd1);
        else       return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/btb_gshare_predictor_if.sv
// Fetch/execute bus of the branch predictor.
//   master : fetch + execute stages (drive PC/resolution, consume prediction)
//   slave  : predictor (drives initDone and the fetch prediction)
interface btb_gshare_predictor_if #(
    parameter int TARGET_WIDTH = 32,
    parameter int GHR_WIDTH    = 8
);
    logic                    initDone;
    logic [31:0]             fetchPc;
    logic                    fetchValid;
    logic                    fetchHit;
    logic                    fetchTaken;
    logic [TARGET_WIDTH-1:0] fetchTarget;
    logic [GHR_WIDTH-1:0]    fetchGhr;
    logic                    exValid;
    logic                    exBranch;
    logic                    exTaken;
    logic                    exMispredict;
    logic [31:0]             exPc;
    logic [TARGET_WIDTH-1:0] exTarget;
    logic [GHR_WIDTH-1:0]    exGhr;

    modport master (
        input  initDone, fetchHit, fetchTaken, fetchTarget, fetchGhr,
        output fetchPc, fetchValid,
        output exValid, exBranch, exTaken, exMispredict, exPc, exTarget, exGhr
    );

    modport slave (
        output initDone, fetchHit, fetchTaken, fetchTarget, fetchGhr,
        input  fetchPc, fetchValid,
        input  exValid, exBranch, exTaken, exMispredict, exPc, exTarget, exGhr
    );
endinterface

// File: rtl/btb_gshare_predictor_pht.sv
// gshare pattern history table: array of 2-bit saturating counters.
//   rd_idx_i/rd_ctr_o     : combinational read (fetch lookup)
//   init_en_i/init_idx_i  : sweep write of CTR_INIT, wins over training
//   upd_en_i/upd_idx_i/upd_taken_i : saturating training update at posedge
// Reads see pre-update contents when read and update hit the same entry.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output ctr_t                rd_ctr_o,
    input  logic                init_en_i,
    input  logic [IDX_BITS-1:0] init_idx_i,
    input  logic                upd_en_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);
    ctr_t pht_q [ENTRIES];

    assign rd_ctr_o = pht_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (init_en_i)
            pht_q[init_idx_i] <= CTR_INIT;
        else if (upd_en_i)
            pht_q[upd_idx_i] <= ctr_next(pht_q[upd_idx_i], upd_taken_i);
    end
endmodule

// File: rtl/btb_gshare_predictor.sv
// Fetch-stage branch predictor: set-associative BTB + gshare PHT +
// speculative global history with mispredict repair.
//   clk, rst (sync, active-low)
//   bp (slave) : fetch lookup (comb, 0 latency) and execute-side training
// After reset an init sweep clears one BTB set and one PHT entry per cycle;
// until it finishes, outputs are held at 0 and all updates are dropped.
module btb_gshare_predictor
    import bp_pkg::*;
#(
    parameter int BTB_SETS     = 64,
    parameter int BTB_WAYS     = 2,
    parameter int TARGET_WIDTH = 32,
    parameter int PHT_ENTRIES  = 256,
    parameter int GHR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    btb_gshare_predictor_if.slave bp
);
    localparam int SET_BITS   = $clog2(BTB_SETS);
    localparam int WAY_BITS   = $clog2(BTB_WAYS);
    localparam int PHT_BITS   = $clog2(PHT_ENTRIES);
    localparam int TAG_WIDTH  = 30 - SET_BITS;
    localparam int SWEEP      = (BTB_SETS > PHT_ENTRIES) ? BTB_SETS : PHT_ENTRIES;
    localparam int SWEEP_BITS = $clog2(SWEEP);

    typedef struct packed {
        logic                    valid;
        logic [TAG_WIDTH-1:0]    tag;
        logic [TARGET_WIDTH-1:0] target;
    } btb_entry_t;

    bp_state_t              state_q, state_d;
    logic [SWEEP_BITS-1:0]  ptr_q, ptr_d;
    logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
    btb_entry_t             btb_q [BTB_SETS][BTB_WAYS];
    logic [WAY_BITS-1:0]    rr_q  [BTB_SETS];

    // rst is folded in so a reset cycle gates outputs and writes immediately
    logic run, sweeping;
    assign run      = rst && (state_q == ST_RUN);
    assign sweeping = rst && (state_q == ST_INIT);

    // ---------------- init sweep FSM ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + SWEEP_BITS'(1);
                if (ptr_q == SWEEP_BITS'(SWEEP - 1)) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    logic                sweep_btb, sweep_pht;
    logic [SET_BITS-1:0] sweep_set;
    assign sweep_btb = sweeping && ({1'b0, ptr_q} < (SWEEP_BITS+1)'(BTB_SETS));
    assign sweep_pht = sweeping && ({1'b0, ptr_q} < (SWEEP_BITS+1)'(PHT_ENTRIES));
    assign sweep_set = SET_BITS'(ptr_q);

    // ---------------- fetch lookup ----------------
    logic [SET_BITS-1:0]     f_set;
    logic [TAG_WIDTH-1:0]    f_tag;
    logic                    f_hit;
    logic [TARGET_WIDTH-1:0] f_tgt;
    ctr_t                    f_ctr;
    assign f_set = bp.fetchPc[SET_BITS+1:2];
    assign f_tag = bp.fetchPc[31:SET_BITS+2];

    // allocation keeps tags unique per set, so OR-ing hit targets is safe
    always_comb begin
        f_hit = 1'b0;
        f_tgt = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (btb_q[f_set][w].valid && btb_q[f_set][w].tag == f_tag) begin
                f_hit = 1'b1;
                f_tgt = f_tgt | btb_q[f_set][w].target;
            end
        end
    end

    assign bp.initDone    = run;
    assign bp.fetchHit    = run && f_hit;
    assign bp.fetchTaken  = bp.fetchHit && f_ctr[1];
    assign bp.fetchTarget = bp.fetchHit ? f_tgt : '0;
    assign bp.fetchGhr    = ghr_q;

    // ---------------- execute training ----------------
    logic [SET_BITS-1:0]  e_set;
    logic [TAG_WIDTH-1:0] e_tag;
    logic                 e_hit, inv_found;
    logic [WAY_BITS-1:0]  e_hit_way, inv_way, wr_way;
    logic                 train, btb_wr, rr_adv;
    assign e_set = bp.exPc[SET_BITS+1:2];
    assign e_tag = bp.exPc[31:SET_BITS+2];

    always_comb begin
        e_hit     = 1'b0;
        e_hit_way = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (btb_q[e_set][w].valid && btb_q[e_set][w].tag == e_tag) begin
                e_hit     = 1'b1;
                e_hit_way = WAY_BITS'(w);
            end
        end
        // walk downward so the lowest invalid way is the one left standing
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (!btb_q[e_set][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign train  = run && bp.exValid && bp.exBranch;
    // hit: refresh target only when taken; miss: allocate only when taken
    assign btb_wr = train && bp.exTaken;
    assign wr_way = e_hit ? e_hit_way : (inv_found ? inv_way : rr_q[e_set]);
    assign rr_adv = btb_wr && !e_hit && !inv_found;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < BTB_SETS; s++) rr_q[s] <= '0;
        end else if (sweep_btb) begin
            for (int w = 0; w < BTB_WAYS; w++) btb_q[sweep_set][w].valid <= 1'b0;
        end else if (btb_wr) begin
            btb_q[e_set][wr_way] <= '{valid: 1'b1, tag: e_tag, target: bp.exTarget};
            if (rr_adv) rr_q[e_set] <= rr_q[e_set] + WAY_BITS'(1);
        end
    end

    gshare_pht #(.ENTRIES(PHT_ENTRIES), .IDX_BITS(PHT_BITS)) u_pht (
        .clk         (clk),
        .rd_idx_i    (bp.fetchPc[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q)),
        .rd_ctr_o    (f_ctr),
        .init_en_i   (sweep_pht),
        .init_idx_i  (PHT_BITS'(ptr_q)),
        .upd_en_i    (train),
        .upd_idx_i   (bp.exPc[PHT_BITS+1:2] ^ PHT_BITS'(bp.exGhr)),
        .upd_taken_i (bp.exTaken)
    );

    // ---------------- global history ----------------
    // repair from the branch's own snapshot beats the same-cycle fetch shift
    always_comb begin
        ghr_d = ghr_q;
        if (train && bp.exMispredict)
            ghr_d = {bp.exGhr[GHR_WIDTH-2:0], bp.exTaken};
        else if (bp.fetchValid && bp.fetchHit)
            ghr_d = {ghr_q[GHR_WIDTH-2:0], bp.fetchTaken};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // PC byte-offset bits carry no branch information
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.fetchPc[1:0], bp.exPc[1:0]};
endmodule

// File: tb/tb_btb_gshare_predictor.sv
module tb_btb_gshare_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btb_gshare_predictor_if bp_if();

    btb_gshare_predictor dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct {
        string       name;
        logic        init;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [7:0]  ghr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic chk_req = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // monitor: compares the combinational prediction mid-cycle
    always @(negedge clk) begin
        if (chk_req) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got a lookup with no expectation queued");
            end else begin
                e = sb.pop_front();
                cmp({e.name, ".initDone"}, 32'(bp_if.initDone),   32'(e.init));
                cmp({e.name, ".hit"},      32'(bp_if.fetchHit),   32'(e.hit));
                cmp({e.name, ".taken"},    32'(bp_if.fetchTaken), 32'(e.taken));
                cmp({e.name, ".target"},   bp_if.fetchTarget,     e.tgt);
                cmp({e.name, ".ghr"},      32'(bp_if.fetchGhr),   32'(e.ghr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic look(string nm, logic [31:0] pc, logic init, logic hit, logic taken,
                        logic [31:0] tgt, logic [7:0] ghr);
        exp_t x;
        x.name = nm; x.init = init; x.hit = hit; x.taken = taken; x.tgt = tgt; x.ghr = ghr;
        bp_if.fetchPc = pc;
        sb.push_back(x);
        chk_req = 1'b1;
        step();
    endtask

    task automatic ex_drv(logic [31:0] pc, logic [31:0] tgt, logic taken, logic mis, logic [7:0] ghr);
        bp_if.exValid      = 1'b1;
        bp_if.exBranch     = 1'b1;
        bp_if.exPc         = pc;
        bp_if.exTarget     = tgt;
        bp_if.exTaken      = taken;
        bp_if.exMispredict = mis;
        bp_if.exGhr        = ghr;
    endtask

    task automatic ex_clr();
        bp_if.exValid      = 1'b0;
        bp_if.exBranch     = 1'b0;
        bp_if.exTaken      = 1'b0;
        bp_if.exMispredict = 1'b0;
        bp_if.exPc         = '0;
        bp_if.exTarget     = '0;
        bp_if.exGhr        = '0;
    endtask

    task automatic train(logic [31:0] pc, logic [31:0] tgt, logic taken, logic [7:0] ghr);
        ex_drv(pc, tgt, taken, 1'b0, ghr);
        step();
        ex_clr();
    endtask

    initial begin
        bp_if.fetchPc    = 32'h100;
        bp_if.fetchValid = 1'b0;
        ex_clr();
        step();

        // reset held: everything gated off
        for (int i = 0; i < 3; i++) look("rst_hold", 32'h100, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        // sweep: exactly 256 cycles with initDone low, no hits
        for (int i = 0; i < 256; i++) look("sweep", 32'h100, 0, 0, 0, 0, 8'h00);
        look("sweep_done", 32'h100, 1, 0, 0, 0, 8'h00);

        // allocate: same-cycle lookup sees the old (empty) BTB
        ex_drv(32'h1000, 32'h2000, 1'b1, 1'b0, 8'h00);
        look("alloc_rbw", 32'h1000, 1, 0, 0, 0, 8'h00);
        ex_clr();
        look("alloc", 32'h1000, 1, 1, 1, 32'h2000, 8'h00);

        // eviction in set 0: 0x1100 fills way1, 0x1200 evicts way0 via rr
        train(32'h1100, 32'h3100, 1'b1, 8'h00);
        train(32'h1200, 32'h3200, 1'b1, 8'h00);
        look("evict_old", 32'h1000, 1, 0, 0, 0,        8'h00);
        look("evict_w1",  32'h1100, 1, 1, 1, 32'h3100, 8'h00);
        look("evict_w0",  32'h1200, 1, 1, 1, 32'h3200, 8'h00);

        // warm PHT[0x81] and PHT[0x83] so three history shifts stay taken
        train(32'h1200, 32'h3200, 1'b1, 8'h01);
        train(32'h1200, 32'h3200, 1'b1, 8'h03);
        bp_if.fetchValid = 1'b1;
        look("ghr_s0", 32'h1200, 1, 1, 1, 32'h3200, 8'h00);
        look("ghr_s1", 32'h1200, 1, 1, 1, 32'h3200, 8'h01);
        look("ghr_s2", 32'h1200, 1, 1, 1, 32'h3200, 8'h03);
        bp_if.fetchValid = 1'b0;
        look("ghr_s3", 32'h1200, 1, 1, 0, 32'h3200, 8'h07);   // PHT[0x87] still 01
        // repair collides with a fetch shift; repair must win
        ex_drv(32'h1200, 32'h3200, 1'b0, 1'b1, 8'h01);
        bp_if.fetchValid = 1'b1;
        look("repair_same", 32'h1200, 1, 1, 0, 32'h3200, 8'h07);
        bp_if.fetchValid = 1'b0;
        ex_clr();
        look("repair_next", 32'h1200, 1, 1, 0, 32'h3200, 8'h02);
        // repair back to zero history (set-0 miss, not taken: no BTB write)
        ex_drv(32'h1300, 32'h0, 1'b0, 1'b1, 8'h00);
        step();
        ex_clr();

        // re-allocate 0x1000: both valid, rr[0]=1 -> way1 (0x1100) evicted
        train(32'h1000, 32'h2000, 1'b1, 8'h00);
        look("rr_evicted", 32'h1100, 1, 0, 0, 0,        8'h00);
        look("rr_new",     32'h1000, 1, 1, 1, 32'h2000, 8'h00);
        look("rr_kept",    32'h1200, 1, 1, 1, 32'h3200, 8'h00);

        // saturation: PHT[0] 11 -> 00 after 4 not-taken; target untouched
        for (int i = 0; i < 4; i++) train(32'h1000, 32'hDEAD, 1'b0, 8'h00);
        look("sat_low", 32'h1000, 1, 1, 0, 32'h2000, 8'h00);
        train(32'h1000, 32'h2000, 1'b1, 8'h00);
        look("sat_up1", 32'h1000, 1, 1, 0, 32'h2000, 8'h00);
        train(32'h1000, 32'h2000, 1'b1, 8'h00);
        look("sat_up2", 32'h1000, 1, 1, 1, 32'h2000, 8'h00);

        // reset mid-operation with a coincident train
        ex_drv(32'h1400, 32'h4400, 1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        look("rst_mid", 32'h1000, 0, 0, 0, 0, 8'h00);
        ex_clr();
        look("rst_mid2", 32'h1000, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) step();
        look("resweep_a", 32'h1000, 1, 0, 0, 0, 8'h00);
        look("resweep_b", 32'h1400, 1, 0, 0, 0, 8'h00);
        look("resweep_c", 32'h1200, 1, 0, 0, 0, 8'h00);

        step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
